buffer_r: RTL and testbench

Receive-side data buffer for the UART core, the counterpart of the transmit buffer. It captures each byte delivered by the receiver shift logic into a small circular FIFO and presents it to the host read interface in arrival order. It reports empty, full and receive-ready status, and records overflow when the receiver delivers a byte with no free slot.

---
 rtl/buffer_r.sv | 152 +++++++++++++++
 tb/tb_buffer_r.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/buffer_r.sv
// buffer_r - receive-side data buffer for the UART core.
//
// Captures bytes from the receiver shift logic into a DEPTH-entry circular
// FIFO. The host pops them in arrival order through a registered read port.
// Status outputs report empty, full and receive-ready. A sticky overflow flag
// records any byte that arrived with no free slot.
//
// Optional feature macro: RX_PARITY_ERR_EN
//   When it is defined, each entry also stores the receiver's parity-error bit.
//   That bit is returned on rPERR together with the popped byte.
//   When it is undefined, rPERRIn is ignored and rPERR is tied low.
//
// Ports:
//   rClk      clock, all logic on the rising edge
//   rRst      synchronous active-high reset, overrides all strobes
//   rWR       receiver write strobe (one byte per cycle)
//   rdataIn   received byte, sampled when rWR=1
//   rPERRIn   parity error of rdataIn (RX_PARITY_ERR_EN only)
//   rRD       host read strobe (one pop per cycle)
//   rOVFCLR   clears the sticky overflow flag
//   rdataOut  registered byte from the last accepted read
//   rPERR     registered parity flag of that byte
//   rEMPTY    FIFO holds 0 entries
//   rFULL     FIFO holds DEPTH entries
//   rxrdy     at least one byte available (== !rEMPTY)
//   rOVF      sticky overflow flag
module buffer_r #(
    parameter int BITWIDTH = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = 2
) (
    input  logic                rClk,
    input  logic                rRst,
    input  logic                rWR,
    input  logic [BITWIDTH-1:0] rdataIn,
    input  logic                rPERRIn,
    input  logic                rRD,
    input  logic                rOVFCLR,
    output logic [BITWIDTH-1:0] rdataOut,
    output logic                rPERR,
    output logic                rEMPTY,
    output logic                rFULL,
    output logic                rxrdy,
    output logic                rOVF
);

`ifdef RX_PARITY_ERR_EN
    localparam int MW = BITWIDTH + 1;
`else
    localparam int MW = BITWIDTH;
`endif

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

    logic [MW-1:0]       mem_r [DEPTH];
    logic [AW-1:0]       wp_r;
    logic [AW-1:0]       rp_r;
    logic [AW:0]         cnt_r;
    logic [BITWIDTH-1:0] dout_r;
    logic                ovf_r;

    logic                rd_ok_s;
    logic                wr_ok_s;
    logic                drop_s;
    logic [MW-1:0]       wr_word_s;
    logic [MW-1:0]       rd_word_s;

    // When the FIFO is full, a write is still accepted if a read frees a slot in the same cycle.
    assign rd_ok_s   = rRD && (cnt_r != CNT_ZERO);
    assign wr_ok_s   = rWR && ((cnt_r != CNT_FULL) || rd_ok_s);
    assign drop_s    = rWR && !wr_ok_s;
    assign rd_word_s = mem_r[rp_r];

`ifdef RX_PARITY_ERR_EN
    logic perr_r;

    assign wr_word_s = {rPERRIn, rdataIn};
    assign rPERR     = perr_r;

    // Parity flag of the popped byte. It follows the same update rules as rdataOut.
    always_ff @(posedge rClk) begin
        if (rRst) begin
            perr_r <= 1'b0;
        end else if (rd_ok_s) begin
            perr_r <= rd_word_s[BITWIDTH];
        end else begin
            perr_r <= perr_r;
        end
    end
`else
    logic unused_perr_s;

    assign wr_word_s     = rdataIn;
    assign unused_perr_s = rPERRIn;
    assign rPERR         = 1'b0;
`endif

    // Storage array. It has no reset; stale contents are unreachable once the pointers are reset.
    always_ff @(posedge rClk) begin
        if (!rRst && wr_ok_s) begin
            mem_r[wp_r] <= wr_word_s;
        end
    end

    // Pointers, occupancy count, read data and the sticky overflow flag.
    always_ff @(posedge rClk) begin
        if (rRst) begin
            wp_r   <= {AW{1'b0}};
            rp_r   <= {AW{1'b0}};
            cnt_r  <= CNT_ZERO;
            dout_r <= {BITWIDTH{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wp_r <= wp_r + 1'b1;
            end else begin
                wp_r <= wp_r;
            end

            if (rd_ok_s) begin
                rp_r   <= rp_r + 1'b1;
                dout_r <= rd_word_s[BITWIDTH-1:0];
            end else begin
                rp_r   <= rp_r;
                dout_r <= dout_r;
            end

            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase

            // If a dropped write and a clear arrive in the same cycle, the set wins.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (rOVFCLR) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign rdataOut = dout_r;
    assign rOVF     = ovf_r;
    assign rEMPTY   = (cnt_r == CNT_ZERO);
    assign rFULL    = (cnt_r == CNT_FULL);
    assign rxrdy    = !rEMPTY;

endmodule

// File: tb/tb_buffer_r.sv
// Directed testbench for buffer_r (DEPTH=4, BITWIDTH=8).
module tb_buffer_r;

    logic       tClk;
    logic       rRst;
    logic       rWR;
    logic [7:0] rdataIn;
    logic       rPERRIn;
    logic       rRD;
    logic       rOVFCLR;
    logic [7:0] rdataOut;
    logic       rPERR;
    logic       rEMPTY;
    logic       rFULL;
    logic       rxrdy;
    logic       rOVF;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [7:0] dout;
        logic       empty;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    buffer_r #(.BITWIDTH(8), .DEPTH(4), .AW(2)) dut (
        .rClk     (tClk),
        .rRst     (rRst),
        .rWR      (rWR),
        .rdataIn  (rdataIn),
        .rPERRIn  (rPERRIn),
        .rRD      (rRD),
        .rOVFCLR  (rOVFCLR),
        .rdataOut (rdataOut),
        .rPERR    (rPERR),
        .rEMPTY   (rEMPTY),
        .rFULL    (rFULL),
        .rxrdy    (rxrdy),
        .rOVF     (rOVF)
    );

    initial tClk = 1'b0;
    always #5 tClk = ~tClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the inputs away from the edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic rst, input logic wr, input logic [7:0] din,
                         input logic perr, input logic rd, input logic clr);
        @(negedge tClk);
        rRst    = rst;
        rWR     = wr;
        rdataIn = din;
        rPERRIn = perr;
        rRD     = rd;
        rOVFCLR = clr;
        @(posedge tClk);
        #1;
    endtask

    task automatic add(input logic rst, input logic wr, input logic [7:0] din,
                       input logic rd, input logic clr, input logic [7:0] dout,
                       input logic empty, input logic full, input logic ovf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
        v.dout = dout; v.empty = empty; v.full = full; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        rRst = 1'b1; rWR = 1'b0; rdataIn = 8'h00; rPERRIn = 1'b0; rRD = 1'b0; rOVFCLR = 1'b0;

        //   rst   wr    din    rd    clr   dout   empty full  ovf
        // Reset for 2 cycles, then idle.
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Fill the FIFO.
        add(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        // Write while full: byte is dropped and the overflow flag sticks.
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        // Drain: the original bytes come out in order.
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 1'b1);
        // Clear the overflow flag, then read while empty (ignored).
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hD4, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 1'b0);
        // Refill.
        add(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'hD4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'hD4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'hD4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'hD4, 1'b0, 1'b1, 1'b0);
        // Full with both strobes: both are accepted and no overflow occurs.
        add(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
        // Dropped write together with a clear: the set wins.
        add(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        // Drain: EE is the 4th pop.
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
        // Empty with both strobes: the write is taken, the read is ignored, and there is no bypass.
        add(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].wr, vecs[i].din, 1'b0, vecs[i].rd, vecs[i].clr);
            check($sformatf("v%0d_dout", i),  {24'h0, rdataOut}, {24'h0, vecs[i].dout});
            check($sformatf("v%0d_empty", i), {31'h0, rEMPTY},   {31'h0, vecs[i].empty});
            check($sformatf("v%0d_rxrdy", i), {31'h0, rxrdy},    {31'h0, !vecs[i].empty});
            check($sformatf("v%0d_full", i),  {31'h0, rFULL},    {31'h0, vecs[i].full});
            check($sformatf("v%0d_ovf", i),   {31'h0, rOVF},     {31'h0, vecs[i].ovf});
            check($sformatf("v%0d_perr", i),  {31'h0, rPERR},    32'h0);
        end

        // Pointer wrap: interleaved write/read pairs.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'(i);
            apply(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0);
            check($sformatf("wrap%0d_wfull", i), {31'h0, rFULL}, 32'h0);
            check($sformatf("wrap%0d_wempty", i), {31'h0, rEMPTY}, 32'h0);
            apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            check($sformatf("wrap%0d_dout", i), {24'h0, rdataOut}, {24'h0, b});
            check($sformatf("wrap%0d_rempty", i), {31'h0, rEMPTY}, 32'h1);
        end

        // Reset mid-stream with 3 bytes buffered and a write in the reset cycle.
        apply(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 8'h83, 1'b0, 1'b0, 1'b0);
        check("pre_rst_empty", {31'h0, rEMPTY}, 32'h0);
        apply(1'b1, 1'b1, 8'h84, 1'b0, 1'b0, 1'b0);
        check("rst_empty", {31'h0, rEMPTY}, 32'h1);
        check("rst_rxrdy", {31'h0, rxrdy}, 32'h0);
        check("rst_dout", {24'h0, rdataOut}, 32'h0);
        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("post_rst_rd_dout", {24'h0, rdataOut}, 32'h0);
        check("post_rst_rd_empty", {31'h0, rEMPTY}, 32'h1);

        // A byte carrying a parity error.
        apply(1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("perr_dout", {24'h0, rdataOut}, 32'h7F);
`ifdef RX_PARITY_ERR_EN
        check("perr_flag", {31'h0, rPERR}, 32'h1);
`else
        check("perr_flag", {31'h0, rPERR}, 32'h0);
`endif
        check("perr_empty", {31'h0, rEMPTY}, 32'h1);

        apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
